alu_arbiter: RTL and testbench

- Shares one 8-bit ALU between two requesters using round-robin arbitration.
- Each requester presents an operation over a valid/ready handshake.
- The block sequences the operation through the ALU, registers the result and flags, and returns them on a single valid/ready response channel tagged with the requester id.
- Sits between the ALU datapath and the requesting control units.

---
 rtl/alu_arbiter_pkg.sv | 13 +
 rtl/alu_arbiter_alu.sv | 25 ++
 rtl/alu_arbiter.sv | 131 +++++++++++++
 tb/tb_alu_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared opcodes, FSM state encoding and default datapath width for alu_arbiter.
package alu_arbiter_pkg;
  localparam int WIDTH = 8;
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_NAND = 3'd5;
  localparam logic [2:0] OP_CMP  = 3'd6;
  localparam logic [2:0] OP_INV  = 3'd7;
  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;
endpackage

// File: rtl/alu_arbiter_alu.sv
// alu_arbiter_alu: combinational ALU (op_i, a_i, b_i -> c_o, carry_o, borrow_o); ops 6 and 7 yield c_o=0.
module alu_arbiter_alu #(
  parameter int WIDTH = alu_arbiter_pkg::WIDTH
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] c_o,
  output logic             carry_o,
  output logic             borrow_o
);
  import alu_arbiter_pkg::*;
  logic [WIDTH:0] sum, dif;
  assign sum = {1'b0, a_i} + {1'b0, b_i};
  assign dif = {1'b0, a_i} - {1'b0, b_i};
  assign carry_o = sum[WIDTH];
  assign borrow_o = dif[WIDTH];
  always_comb
    c_o = op_i == OP_ADD  ? sum[WIDTH-1:0] :
          op_i == OP_SUB  ? dif[WIDTH-1:0] :
          op_i == OP_XOR  ? a_i ^ b_i :
          op_i == OP_AND  ? a_i & b_i :
          op_i == OP_NOR  ? ~(a_i | b_i) :
          op_i == OP_NAND ? ~(a_i & b_i) : '0;
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one ALU between two valid/ready requesters; registered, id-tagged response channel, busy flag and completion counter.
module alu_arbiter #(
  parameter int WIDTH = alu_arbiter_pkg::WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_c,
  output logic             rsp_carry,
  output logic             rsp_borrow,
  output logic             rsp_equal,
  output logic             rsp_less,
  output logic             rsp_more,
  output logic             rsp_err,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);
  import alu_arbiter_pkg::*;
  state_t state_q, state_d;
  logic last_q, last_d, id_q, id_d;
  logic [2:0] op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, alu_c;
  logic carry_q, carry_d, borrow_q, borrow_d, eq_q, eq_d, lt_q, lt_d, gt_q, gt_d, err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic alu_carry, alu_borrow, gnt0, gnt1, is_cmp;
  alu_arbiter_alu #(.WIDTH(WIDTH)) u_alu (
    .op_i(op_q), .a_i(a_q), .b_i(b_q), .c_o(alu_c), .carry_o(alu_carry), .borrow_o(alu_borrow)
  );
  // On a tie the requester that did not win last time is granted.
  assign gnt0 = req0_valid & (~req1_valid | last_q);
  assign gnt1 = req1_valid & (~req0_valid | ~last_q);
  assign req0_ready = (state_q == ST_IDLE) & gnt0;
  assign req1_ready = (state_q == ST_IDLE) & gnt1;
  assign is_cmp = op_q == OP_CMP;
  assign rsp_valid = state_q == ST_RESP;
  assign busy = state_q != ST_IDLE;
  assign rsp_id = id_q;
  assign rsp_c = c_q;
  assign rsp_carry = carry_q;
  assign rsp_borrow = borrow_q;
  assign rsp_equal = eq_q;
  assign rsp_less = lt_q;
  assign rsp_more = gt_q;
  assign rsp_err = err_q;
  assign op_count = cnt_q;
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    id_d = id_q;
    op_d = op_q;
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    carry_d = carry_q;
    borrow_d = borrow_q;
    eq_d = eq_q;
    lt_d = lt_q;
    gt_d = gt_q;
    err_d = err_q;
    cnt_d = cnt_q;
    if (state_q == ST_IDLE && (gnt0 | gnt1)) begin
      id_d = gnt1;
      last_d = gnt1;
      op_d = gnt1 ? req1_op : req0_op;
      a_d = gnt1 ? req1_a : req0_a;
      b_d = gnt1 ? req1_b : req0_b;
      state_d = ST_EXEC;
    end
    if (state_q == ST_EXEC) begin
      // Every flag is recomputed from the current op so nothing leaks from a previous response.
      c_d = (is_cmp || op_q == OP_INV) ? '0 : alu_c;
      carry_d = (op_q == OP_ADD) & alu_carry;
      borrow_d = (op_q == OP_SUB) & alu_borrow;
      eq_d = is_cmp & (a_q == b_q);
      lt_d = is_cmp & (a_q < b_q);
      gt_d = is_cmp & (a_q > b_q);
      err_d = op_q == OP_INV;
      state_d = ST_RESP;
    end
    if (state_q == ST_RESP && rsp_ready) begin
      cnt_d = cnt_q + 1'b1;
      state_d = ST_IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q <= 1'b1;
      id_q <= 1'b0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      carry_q <= 1'b0;
      borrow_q <= 1'b0;
      eq_q <= 1'b0;
      lt_q <= 1'b0;
      gt_q <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      id_q <= id_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      carry_q <= carry_d;
      borrow_q <= borrow_d;
      eq_q <= eq_d;
      lt_q <= lt_d;
      gt_q <= gt_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with directed and random traffic.
module tb_alu_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic req0_valid = 0, req1_valid = 0, rsp_ready = 1;
  logic req0_ready, req1_ready, rsp_valid, rsp_id, busy;
  logic [2:0] req0_op = 0, req1_op = 0;
  logic [7:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0, rsp_c;
  logic rsp_carry, rsp_borrow, rsp_equal, rsp_less, rsp_more, rsp_err;
  logic [15:0] op_count;
  typedef struct packed {logic id; logic [7:0] c; logic carry, borrow, eq, lt, gt, err;} rsp_t;
  rsp_t q[$];
  int acc_cyc[$];
  int grants[$];
  int checks = 0, errors = 0, cyc = 0, exp_cnt = 0;
  bit last_id = 1, prev_hs = 0, done = 0;
  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_c(rsp_c),
    .rsp_carry(rsp_carry), .rsp_borrow(rsp_borrow), .rsp_equal(rsp_equal), .rsp_less(rsp_less),
    .rsp_more(rsp_more), .rsp_err(rsp_err), .busy(busy), .op_count(op_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, exp, $time);
    end
  endtask
  function automatic rsp_t model(input bit id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    rsp_t r;
    int s;
    r = '0;
    r.id = id;
    case (op)
      3'd0: begin s = int'(a) + int'(b); r.c = 8'(s % 256); r.carry = s > 255; end
      3'd1: begin s = int'(a) + 256 - int'(b); r.c = 8'(s % 256); r.borrow = a < b; end
      3'd2: r.c = a ^ b;
      3'd3: r.c = a & b;
      3'd4: r.c = ~(a | b);
      3'd5: r.c = ~(a & b);
      3'd6: begin r.eq = a == b; r.lt = a < b; r.gt = a > b; end
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction
  always @(negedge clk) begin
    bit id;
    if (!rst) begin
      if (req0_ready | req1_ready)
        chk("ready_valid", {req0_ready & ~req0_valid, req1_ready & ~req1_valid, req0_ready & req1_ready}, 0);
      if (!busy && (req0_valid | req1_valid)) chk("grant", req0_ready | req1_ready, 1);
      if ((req0_valid & req0_ready) | (req1_valid & req1_ready)) begin
        id = req1_ready;
        if (req0_valid & req1_valid) chk("rr_grant", id, !last_id);
        last_id = id;
        q.push_back(id ? model(1, req1_op, req1_a, req1_b) : model(0, req0_op, req0_a, req0_b));
        acc_cyc.push_back(cyc);
        grants.push_back(id);
      end
    end
  end
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_hs) chk("idle_after_rsp", busy, 0);
      prev_hs = rsp_valid & rsp_ready;
      if (rsp_valid) begin
        if (q.size() == 0) chk("spurious_rsp", rsp_valid, 0);
        else begin
          if (acc_cyc.size() != 0) chk("latency", cyc - acc_cyc.pop_front(), 2);
          chk("rsp", {rsp_id, rsp_c, rsp_carry, rsp_borrow, rsp_equal, rsp_less, rsp_more, rsp_err}, q[0]);
          chk("busy_ready", {busy, req0_ready, req1_ready}, 3'b100);
          chk("op_count", op_count, exp_cnt);
          if (rsp_ready) begin
            void'(q.pop_front());
            exp_cnt = (exp_cnt + 1) % 65536;
          end
        end
      end
    end
  end
  task automatic clear_sb();
    q.delete();
    acc_cyc.delete();
    grants.delete();
    exp_cnt = 0;
    last_id = 1;
    prev_hs = 0;
  endtask
  task automatic do_reset();
    rst = 1;
    clear_sb();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("reset_out", {rsp_valid, busy, rsp_id, rsp_c, rsp_carry, rsp_borrow, rsp_equal, rsp_less, rsp_more, rsp_err, req0_ready, req1_ready}, 0);
    chk("reset_cnt", op_count, 0);
  endtask
  task automatic send(input bit id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    if (id) begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
    else begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
    do begin @(negedge clk); n++; end while (!(id ? req1_ready : req0_ready) && n < 100);
    if (n >= 100) chk("hs_timeout", id ? req1_ready : req0_ready, 1);
    @(posedge clk);
    #1;
    if (id) req1_valid = 0; else req0_valid = 0;
  endtask
  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || rsp_valid) && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) chk("drain_timeout", q.size(), 0);
  endtask
  initial begin
    logic [3:0] g;
    do_reset();
    send(0, 3'd0, 8'd200, 8'd100);
    drain();
    chk("op_count_first", op_count, 1);
    do_reset();
    fork
      begin send(0, 3'd0, 8'd1, 8'd1); send(0, 3'd0, 8'd2, 8'd2); end
      begin send(1, 3'd1, 8'd3, 8'd1); send(1, 3'd1, 8'd4, 8'd1); end
    join
    drain();
    if (grants.size() != 4) chk("grant_count", grants.size(), 4);
    else begin
      for (int i = 0; i < 4; i++) g[3-i] = grants[i][0];
      chk("grant_order", g, 4'b0101);
    end
    send(1, 3'd1, 8'd5, 8'd10);
    send(1, 3'd1, 8'd10, 8'd5);
    send(0, 3'd6, 8'd7, 8'd7);
    send(0, 3'd6, 8'd3, 8'd9);
    send(0, 3'd4, 8'd0, 8'd0);
    drain();
    rsp_ready = 0;
    send(0, 3'd3, 8'hF0, 8'h3C);
    fork send(1, 3'd2, 8'hAA, 8'h55); join_none
    repeat (6) begin @(posedge clk); #1; end
    chk("bp_hold", {rsp_valid, busy}, 2'b11);
    rsp_ready = 1;
    wait fork;
    drain();
    send(0, 3'd7, 8'd9, 8'd9);
    drain();
    send(0, 3'd0, 8'd1, 8'd2);
    chk("exec_busy", {busy, rsp_valid}, 2'b10);
    #2 rst = 1;
    #1;
    chk("rst_mid_out", {rsp_valid, busy, rsp_id, rsp_c, rsp_carry, rsp_borrow, rsp_equal, rsp_less, rsp_more, rsp_err, req0_ready, req1_ready}, 0);
    chk("rst_mid_cnt", op_count, 0);
    clear_sb();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (5) begin @(posedge clk); #1; end
    chk("rst_mid_cnt_after", op_count, 0);
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          send(0, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
        end
      end
      begin
        for (int j = 0; j < 60; j++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          send(1, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
        end
      end
      begin
        while (!done) begin @(posedge clk); #1; rsp_ready = $urandom_range(0, 3) != 0; end
      end
      begin
        #60000;
        chk("global_timeout", done, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
      end
    join_any
    wait (req0_valid == 0 && req1_valid == 0);
    #200;
    done = 1;
    rsp_ready = 1;
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
